// File: rtl/clock_group_reset_sequencer.sv
// Sequences reset and clock enable for one clock-group domain: power-on release plus a software-driven quiesce/reset.
// Latency: release at edge SYNC_STAGES+HOLD_CYCLES+1; soft reset is QUIESCE (<= timeout) plus HOLD_CYCLES; no backpressure, requests outside RUN are dropped.
module clock_group_reset_sequencer #(
    parameter int SYNC_STAGES     = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int QUIESCE_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sw_rst_req,
    input  logic       domain_idle,
    output logic       out_reset,
    output logic       out_clock_en,
    output logic       ready,
    output logic       sw_rst_ack,
    output logic [7:0] sw_rst_count
);

    typedef enum logic [2:0] {
        ASSERT,
        HOLD,
        RUN,
        QUIESCE,
        SW_HOLD
    } state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
    localparam logic [7:0] QTO_LD  = 8'(QUIESCE_TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst;
    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             count_q, count_d;
    logic                   req_d_q;
    logic                   out_reset_q, out_clock_en_q, ready_q, ack_q;
    logic                   sw_done;

    assign sync_rst = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_done = 1'b0;
        case (state_q)
            ASSERT: begin
                if (!sync_rst) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt_q <= 8'd1) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RUN: begin
                // Only a fresh rising edge starts a sequence; a level held past the ack does not.
                if (sw_rst_req && !req_d_q) begin
                    state_d = QUIESCE;
                    cnt_d   = QTO_LD;
                end
            end
            QUIESCE: begin
                if (domain_idle || cnt_q <= 8'd1) begin
                    state_d = SW_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SW_HOLD: begin
                if (cnt_q <= 8'd1) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                    sw_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = 8'd0;
            end
        endcase
        count_d = (sw_done && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q         <= '1;
            state_q        <= ASSERT;
            cnt_q          <= 8'd0;
            count_q        <= 8'd0;
            req_d_q        <= 1'b0;
            out_reset_q    <= 1'b1;
            out_clock_en_q <= 1'b0;
            ready_q        <= 1'b0;
            ack_q          <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], 1'b0};
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            count_q        <= count_d;
            req_d_q        <= sw_rst_req;
            // Outputs are registered from the next state so they line up with the state register.
            out_reset_q    <= (state_d != RUN) && (state_d != QUIESCE);
            out_clock_en_q <= (state_d != ASSERT);
            ready_q        <= (state_d == RUN);
            ack_q          <= sw_done;
        end
    end

    assign out_reset    = out_reset_q;
    assign out_clock_en = out_clock_en_q;
    assign ready        = ready_q;
    assign sw_rst_ack   = ack_q;
    assign sw_rst_count = count_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for clock_group_reset_sequencer; expected ack counts travel through a scoreboard queue.
module tb_clock_group_reset_sequencer;

    localparam int H = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       sw_rst_req;
    logic       domain_idle;
    logic       out_reset;
    logic       out_clock_en;
    logic       ready;
    logic       sw_rst_ack;
    logic [7:0] sw_rst_count;

    int         n_vec = 0;
    int         n_err = 0;
    int         ack_total = 0;
    int         model_cnt = 0;
    int         base;
    logic [7:0] exp_q[$];

    clock_group_reset_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .sw_rst_req   (sw_rst_req),
        .domain_idle  (domain_idle),
        .out_reset    (out_reset),
        .out_clock_en (out_clock_en),
        .ready        (ready),
        .sw_rst_ack   (sw_rst_ack),
        .sw_rst_count (sw_rst_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (sw_rst_ack === 1'b1) ack_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_req();
        model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
        exp_q.push_back(8'(model_cnt));
        sw_rst_req = 1'b1;
    endtask

    task automatic pop_chk();
        if (exp_q.size() == 0) begin
            chk("sb_underflow", exp_q.size(), 1);
        end else begin
            chk("sb_count", sw_rst_count, exp_q.pop_front());
        end
    endtask

    // Releases reset between edges and checks every edge of the power-on sequence.
    task automatic release_check(input int pulse_at);
        @(negedge clock);
        reset = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clock);
            #1;
            chk("rel_clk_en", out_clock_en, e >= 4);
            chk("rel_reset", out_reset, e < 20);
            chk("rel_ready", ready, e >= 20);
            chk("rel_ack", sw_rst_ack, 0);
            if (pulse_at > 0 && e == pulse_at) sw_rst_req = 1'b1;
            else if (pulse_at > 0 && e == pulse_at + 1) sw_rst_req = 1'b0;
        end
    endtask

    // Request must already be raised; q is the expected number of QUIESCE cycles.
    task automatic run_sw(input int q);
        for (int k = 1; k <= q + H + 3; k++) begin
            @(posedge clock);
            #1;
            chk("sw_reset", out_reset, (k > q) && (k <= q + H));
            chk("sw_ready", ready, k > q + H);
            chk("sw_clk_en", out_clock_en, 1);
            chk("sw_ack", sw_rst_ack, k == q + H + 1);
            if (sw_rst_ack === 1'b1) pop_chk();
        end
    endtask

    task automatic quick_req();
        logic seen;
        seen = 1'b0;
        @(negedge clock);
        push_req();
        for (int c = 0; c < 64 && !seen; c++) begin
            @(posedge clock);
            #1;
            if (sw_rst_ack === 1'b1) begin
                seen = 1'b1;
                pop_chk();
            end
        end
        chk("ack_seen", seen, 1);
        @(negedge clock);
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset       = 1'b1;
        sw_rst_req  = 1'b0;
        domain_idle = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_out_reset", out_reset, 1);
        chk("rst_clk_en", out_clock_en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ack", sw_rst_ack, 0);
        chk("rst_count", sw_rst_count, 0);

        // Power-on release with defaults
        release_check(0);
        chk("rel_no_ack", ack_total, 0);

        // Idle domain: one QUIESCE cycle then HOLD_CYCLES of reset
        domain_idle = 1'b1;
        @(negedge clock);
        push_req();
        run_sw(1);
        chk("idle_count", sw_rst_count, 1);
        @(negedge clock);
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clock);

        // Busy domain: full timeout, then a held request must not retrigger
        domain_idle = 1'b0;
        base = ack_total;
        @(negedge clock);
        push_req();
        run_sw(255);
        repeat (40) @(negedge clock);
        chk("held_one_ack", ack_total, base + 1);
        chk("held_ready", ready, 1);
        chk("held_count", sw_rst_count, 2);
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clock);

        // Saturation of the completion counter
        domain_idle = 1'b1;
        for (int i = 0; i < 256; i++) quick_req();
        chk("sat_count", sw_rst_count, 255);
        quick_req();
        chk("sat_stays", sw_rst_count, 255);

        // Reset asserted inside SW_HOLD aborts without an ack
        base = ack_total;
        @(negedge clock);
        push_req();
        repeat (4) @(posedge clock);
        #2;
        chk("pre_abort_reset", out_reset, 1);
        reset = 1'b1;
        #1;
        chk("abort_reset", out_reset, 1);
        chk("abort_clk_en", out_clock_en, 0);
        chk("abort_ready", ready, 0);
        chk("abort_ack", sw_rst_ack, 0);
        chk("abort_count", sw_rst_count, 0);
        sw_rst_req = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        repeat (3) @(negedge clock);
        chk("abort_no_ack", ack_total, base);
        release_check(0);
        chk("abort_rel_no_ack", ack_total, base);
        chk("abort_rel_count", sw_rst_count, 0);

        // Request pulsed during HOLD is dropped
        reset = 1'b1;
        repeat (2) @(negedge clock);
        base = ack_total;
        release_check(8);
        repeat (20) @(negedge clock);
        chk("hold_pulse_ack", ack_total, base);
        chk("hold_pulse_count", sw_rst_count, 0);
        chk("hold_pulse_ready", ready, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_group_reset_sequencer.md
CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, meaning reset-deassertion synchronizer depth (legal 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning cycles out_reset stays high with the clock enabled before release (legal 1..255).
REQ-003 SHALL have parameter QUIESCE_TIMEOUT, default 255, meaning the maximum number of QUIESCE cycles spent waiting for domain_idle (legal 1..255).
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-006 SHALL have port sw_rst_req, input, 1, meaning the level software request for a domain reset.
REQ-007 SHALL have port domain_idle, input, 1, meaning the domain reports no outstanding transactions.
REQ-008 SHALL have port out_reset, output, 1, meaning the registered, synchronously deasserted reset to the member domain.
REQ-009 SHALL have port out_clock_en, output, 1, meaning the registered clock-gate enable for the member domain.
REQ-010 SHALL have port ready, output, 1, meaning the domain is out of reset and running.
REQ-011 SHALL have port sw_rst_ack, output, 1, meaning a one-cycle completion pulse for sw_rst_req.
REQ-012 SHALL have port sw_rst_count, output, 8, meaning the count of completed software resets.

Function
REQ-013 SHALL use states ASSERT, HOLD, RUN, QUIESCE and SW_HOLD, with all outputs driven from registers.
REQ-014 SHALL implement the synchronizer as SYNC_STAGES flops that are set to 1 by reset and shift in 0 each cycle; sync_rst is the last stage.
REQ-015 In ASSERT: out_reset=1, out_clock_en=0 and ready=0; go to HOLD on the first edge where sync_rst==0.
REQ-016 In HOLD: out_clock_en=1 and out_reset=1; the down-counter is loaded with HOLD_CYCLES on entry; go to RUN after HOLD_CYCLES cycles in HOLD.
REQ-017 out_reset SHALL fall on exactly the (SYNC_STAGES+HOLD_CYCLES+1)th rising edge after reset deasserts.
REQ-018 In RUN: out_reset=0, out_clock_en=1 and ready=1.
REQ-019 A sw_rst_req rising edge seen in RUN (req high now, registered req_d low) SHALL move the block to QUIESCE; a level held high after a previous ack SHALL NOT retrigger.
REQ-020 In QUIESCE: ready=0 and out_reset=0; the timeout counter is loaded with QUIESCE_TIMEOUT on entry; go to SW_HOLD when domain_idle==1 or when the counter reaches 0, whichever comes first.
REQ-021 In SW_HOLD: out_reset=1 and out_clock_en=1 for HOLD_CYCLES cycles; on exit, pulse sw_rst_ack for exactly 1 cycle, increment sw_rst_count, and go to RUN.
REQ-022 sw_rst_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-023 If sw_rst_req drops during QUIESCE or SW_HOLD, the sequence SHALL complete anyway, including the ack.
REQ-024 If domain_idle==1 and the timeout reaches 0 in the same cycle, the block SHALL take the single transition to SW_HOLD.
REQ-025 A sw_rst_req rising edge outside RUN SHALL be ignored and SHALL NOT be queued.

Reset
REQ-026 Assertion of reset SHALL, asynchronously and in any state: set the synchronizer to all 1s, state=ASSERT, out_reset=1, out_clock_en=0, ready=0, sw_rst_ack=0, sw_rst_count=0, req_d=0, and clear both counters.
REQ-027 Reset asserted mid-sequence (HOLD, QUIESCE or SW_HOLD) SHALL abort with no ack pulse and no count increment.
REQ-028 Deassertion of reset SHALL take effect only through the synchronizer; no output may change on a non-clock edge except at reset assertion.

Verification
REQ-029 Defaults; release reset -> out_clock_en rises at edge 4, out_reset falls and ready rises at edge 20, sw_rst_ack stays 0.
REQ-030 In RUN, raise sw_rst_req with domain_idle=1 -> QUIESCE for 1 cycle, out_reset high for 16 cycles, one sw_rst_ack pulse, sw_rst_count=1, ready returns high.
REQ-031 In RUN, hold domain_idle=0 and raise sw_rst_req -> SW_HOLD entered after 255 QUIESCE cycles, ack pulses once; keeping req high afterwards -> no second reset.
REQ-032 Run 256 request/drop cycles -> sw_rst_count reads 255 and stays 255.
REQ-033 Assert reset during SW_HOLD -> out_reset=1 and out_clock_en=0 immediately, no ack, count=0, then the normal 20-edge release.
REQ-034 Pulse sw_rst_req during HOLD -> ignored; ready rises on schedule, count stays 0.
